// File: rtl/ktne_in_pkg.sv
// Shared types and defaults for the KTNE input conditioner.
package ktne_in_pkg;

  // Per-key debounced button state; KeyHeld exists only with KTNE_IN_LONGPRESS_EN.
  typedef enum logic [1:0] {
    KeyReleased = 2'd0,
    KeyPressed  = 2'd1,
    KeyHeld     = 2'd2
  } key_state_t;

  localparam int unsigned TICK_DIV_1MS_50MHZ = 50000;
  localparam int unsigned STABLE_TICKS_DEF   = 16;

  // Width of a counter that holds values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ktne_debounce_bit.sv
// One-bit two-flop synchroniser plus tick-based debounce counter.
// rise_o/fall_o are registered alongside stable_q, so each pulse lines up with
// the first cycle showing the new level; en_i gates the pulses, not the level.
module ktne_debounce_bit
  import ktne_in_pkg::*;
#(
  parameter int unsigned StableTicks = STABLE_TICKS_DEF,
  parameter bit          Invert      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic en_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = cnt_width(StableTicks);
  localparam logic [CntW-1:0] CntLast = CntW'(StableTicks - 1);

  logic [1:0]      sync_q, sync_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            synced;

  // Inversion happens after the synchroniser; raw reset value maps to level 0.
  assign synced = sync_q[1] ^ Invert;

  // Next-state: sync shift, debounce count, level update and edge pulses.
  always_comb begin
    sync_d   = {sync_q[0], raw_i};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CntLast) begin
        stable_d = synced;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = en_i & stable_d & ~stable_q;
    fall_d = en_i & ~stable_d & stable_q;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= {2{Invert}};
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/ktne_input_conditioner.sv
// KTNE input front end: synchronises and debounces KEY_N / SW_RAW and produces
// clean levels plus one-cycle press/release/change events.
// Optional feature: define KTNE_IN_LONGPRESS_EN for the HELD state and key_long.
module ktne_input_conditioner
  import ktne_in_pkg::*;
#(
  parameter int unsigned TICK_DIV     = TICK_DIV_1MS_50MHZ,
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned NUM_KEY      = 2,
  parameter int unsigned NUM_SW       = 18
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic [NUM_KEY-1:0] KEY_N,
  input  logic [NUM_SW-1:0]  SW_RAW,
  output logic               ready,
  output logic [NUM_KEY-1:0] key_level,
  output logic [NUM_KEY-1:0] key_press,
  output logic [NUM_KEY-1:0] key_release,
  output logic [NUM_KEY-1:0] key_long,
  output logic [NUM_SW-1:0]  sw_level,
  output logic               sw_change,
  output logic [NUM_SW-1:0]  sw_change_mask
);

  localparam int unsigned DivW = cnt_width(TICK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
  localparam int unsigned RdyW = cnt_width(STABLE_TICKS);
  localparam logic [RdyW-1:0] RdyLast = RdyW'(STABLE_TICKS - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [RdyW-1:0] rdy_cnt_q, rdy_cnt_d;
  logic            ready_q, ready_d;
  logic            tick;
  logic [NUM_SW-1:0] sw_rise, sw_fall;

  assign tick = (div_q == DivLast);

  // Prescaler and settling window: ready rises after STABLE_TICKS ticks.
  always_comb begin
    div_d     = tick ? '0 : div_q + 1'b1;
    rdy_cnt_d = rdy_cnt_q;
    ready_d   = ready_q;
    if (!ready_q && tick) begin
      if (rdy_cnt_q == RdyLast) begin
        ready_d = 1'b1;
      end else begin
        rdy_cnt_d = rdy_cnt_q + 1'b1;
      end
    end
  end

  // Prescaler / settling registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q     <= '0;
      rdy_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      div_q     <= div_d;
      rdy_cnt_q <= rdy_cnt_d;
      ready_q   <= ready_d;
    end
  end

  assign ready = ready_q;

  for (genvar k = 0; k < NUM_KEY; k++) begin : g_key
    ktne_debounce_bit #(
      .StableTicks(STABLE_TICKS),
      .Invert     (1'b1)
    ) u_db (
      .clk_i   (CLOCK_50),
      .rst_ni  (RESET_N),
      .tick_i  (tick),
      .en_i    (ready_q),
      .raw_i   (KEY_N[k]),
      .stable_o(key_level[k]),
      .rise_o  (key_press[k]),
      .fall_o  (key_release[k])
    );

`ifdef KTNE_IN_LONGPRESS_EN
    localparam int unsigned HoldW = cnt_width(LONG_TICKS);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_TICKS - 1);

    key_state_t       state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             long_q, long_d;

    // Key FSM: hold counter runs in PRESSED, saturates in HELD, clears on release.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      long_d  = 1'b0;
      unique case (state_q)
        KeyReleased: begin
          hold_d = '0;
          if (key_level[k]) state_d = KeyPressed;
        end
        KeyPressed: begin
          if (!key_level[k]) begin
            state_d = KeyReleased;
            hold_d  = '0;
          end else if (tick) begin
            if (hold_q == HoldLast) begin
              state_d = KeyHeld;
              long_d  = ready_q;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        KeyHeld: begin
          if (!key_level[k]) begin
            state_d = KeyReleased;
            hold_d  = '0;
          end
        end
        default: begin
          state_d = KeyReleased;
          hold_d  = '0;
        end
      endcase
    end

    // Key FSM registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        state_q <= KeyReleased;
        hold_q  <= '0;
        long_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        long_q  <= long_d;
      end
    end

    assign key_long[k] = long_q;
`else
    // Two-state FSM (RELEASED/PRESSED) is exactly the debounced level; the
    // press/release pulses come straight from the debouncer edges.
    assign key_long[k] = 1'b0;
`endif
  end

  for (genvar s = 0; s < NUM_SW; s++) begin : g_sw
    ktne_debounce_bit #(
      .StableTicks(STABLE_TICKS),
      .Invert     (1'b0)
    ) u_db (
      .clk_i   (CLOCK_50),
      .rst_ni  (RESET_N),
      .tick_i  (tick),
      .en_i    (ready_q),
      .raw_i   (SW_RAW[s]),
      .stable_o(sw_level[s]),
      .rise_o  (sw_rise[s]),
      .fall_o  (sw_fall[s])
    );
  end

  // Mask bits are registered pulses, so the mask is zero outside a change cycle.
  assign sw_change_mask = sw_rise | sw_fall;
  assign sw_change      = |sw_change_mask;

endmodule

// File: tb/tb_ktne_input_conditioner.sv
// Directed self-checking bench for ktne_input_conditioner (TICK_DIV=4,
// STABLE_TICKS=3, LONG_TICKS=5).
module tb_ktne_input_conditioner;

`ifdef KTNE_IN_LONGPRESS_EN
  localparam int LongExp = 1;
`else
  localparam int LongExp = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  key_n;
  logic [17:0] sw_raw;
  logic        ready;
  logic [1:0]  key_level, key_press, key_release, key_long;
  logic [17:0] sw_level, sw_change_mask;
  logic        sw_change;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int n_press[2] = '{0, 0};
  int n_rel[2]   = '{0, 0};
  int n_long[2]  = '{0, 0};
  int press_cyc[2] = '{0, 0};
  int long_cyc[2]  = '{0, 0};
  int n_chg = 0;
  int n_bad = 0;
  logic [17:0] last_mask = '0;

  ktne_input_conditioner #(
    .TICK_DIV    (4),
    .STABLE_TICKS(3),
    .LONG_TICKS  (5),
    .NUM_KEY     (2),
    .NUM_SW      (18)
  ) dut (
    .CLOCK_50      (clk),
    .RESET_N       (rst_n),
    .KEY_N         (key_n),
    .SW_RAW        (sw_raw),
    .ready         (ready),
    .key_level     (key_level),
    .key_press     (key_press),
    .key_release   (key_release),
    .key_long      (key_long),
    .sw_level      (sw_level),
    .sw_change     (sw_change),
    .sw_change_mask(sw_change_mask)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (key_press[k]) begin
        n_press[k]++;
        press_cyc[k] = cyc;
      end
      if (key_release[k]) n_rel[k]++;
      if (key_long[k]) begin
        n_long[k]++;
        long_cyc[k] = cyc;
      end
      if (key_press[k] && key_release[k]) n_bad++;
    end
    if (sw_change) begin
      n_chg++;
      last_mask = sw_change_mask;
    end
    if (!sw_change && sw_change_mask != '0) n_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (ready !== 1'b1 && n <= budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_key(input int k, input logic v, input int budget, output int n);
    n = 0;
    while (key_level[k] !== v && n <= budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int base_chg, base_sum;

    rst_n  = 1'b0;
    key_n  = 2'b11;
    sw_raw = 18'h00008;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_key_level", {30'd0, key_level}, 32'd0);
    check("rst_sw_level", {14'd0, sw_level}, 32'd0);
    check("rst_pulses", {12'd0, key_press, key_release, key_long, sw_change, sw_change_mask},
          32'd0);

    // Settling with SW_RAW[3] held up: level comes up with ready, no event.
    rst_n = 1'b1;
    wait_ready(30, n);
    check("ready_latency", n, 32'd12);
    check("settle_sw_level", {14'd0, sw_level}, 32'h00008);
    check("settle_no_sw_change", n_chg, 32'd0);
    check("settle_key_level", {30'd0, key_level}, 32'd0);

    // Clean press of KEY0.
    key_n[0] = 1'b0;
    wait_key(0, 1'b1, 30, n);
    check("press0_latency_in_10_14", {31'd0, (n >= 10 && n <= 14)}, 32'd1);
    check("press0_count", n_press[0], 32'd1);

    // Long press (only counted with the long-press feature).
    repeat (24) @(negedge clk);
    check("long0_count", n_long[0], LongExp);
`ifdef KTNE_IN_LONGPRESS_EN
    check("long0_delay", long_cyc[0] - press_cyc[0], 32'd20);
`endif

    // Release KEY0: only key_release pulses.
    key_n[0] = 1'b1;
    wait_key(0, 1'b0, 30, n);
    check("release0_seen", {31'd0, (n <= 14)}, 32'd1);
    check("release0_count", n_rel[0], 32'd1);
    check("press0_count_after_rel", n_press[0], 32'd1);
    check("long0_count_after_rel", n_long[0], LongExp);

    // Bouncing KEY1 every 5 cycles: never accepted.
    for (int i = 0; i < 8; i++) begin
      key_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (5) @(negedge clk);
    end
    check("bounce_key1_level", {31'd0, key_level[1]}, 32'd0);
    check("bounce_key1_events", n_press[1] + n_rel[1], 32'd0);
    key_n[1] = 1'b0;
    wait_key(1, 1'b1, 30, n);
    check("press1_latency_le_14", {31'd0, (n <= 14)}, 32'd1);
    check("press1_count", n_press[1], 32'd1);

    // Two switches flip in one cycle: one change, two mask bits.
    base_chg = n_chg;
    sw_raw = 18'h20009;
    n = 0;
    while (n_chg == base_chg && n <= 30) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("sw_change_count", n_chg - base_chg, 32'd1);
    check("sw_change_mask", {14'd0, last_mask}, 32'h20001);
    check("sw_level_after", {14'd0, sw_level}, 32'h20009);

    // Reset mid-debounce of a KEY1 release.
    key_n[1] = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_debounce_key1_level", {31'd0, key_level[1]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_levels", {12'd0, key_level, sw_level}, 32'd0);
    check("midrst_pulses", {12'd0, key_press, key_release, key_long, sw_change, sw_change_mask},
          32'd0);
    base_sum = n_press[0] + n_press[1] + n_rel[0] + n_rel[1] + n_long[0] + n_long[1] + n_chg;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(30, n);
    check("rerst_ready_latency", n, 32'd12);
    repeat (2) @(negedge clk);
    check("rerst_no_pulses",
          n_press[0] + n_press[1] + n_rel[0] + n_rel[1] + n_long[0] + n_long[1] + n_chg - base_sum,
          32'd0);
    check("rerst_sw_level", {14'd0, sw_level}, 32'h20009);
    check("rerst_key_level", {30'd0, key_level}, 32'd0);
    check("pulse_rules", n_bad, 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
